// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller for the MEM stage.
// Misses stall the pipeline while whole lines move over an enable/ack memory handshake.
module dcache_ctrl #(
  parameter int unsigned INDEX_BITS = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  input  logic         cpu_memread_i,
  input  logic         cpu_memwrite_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  localparam int unsigned LINES     = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS  = 32 - INDEX_BITS - 5;
  localparam int unsigned LINE_BITS = 256;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];

  logic [2:0]            word;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic [LINE_BITS-1:0]  line;
  logic [TAG_BITS-1:0]   victim_tag;
  logic                  request;
  logic                  hit;
  logic                  fill;
  logic                  store_hit;
  logic                  unused_addr_bits;

  logic                  mem_enable_d;
  logic                  mem_write_d;
  logic [31:0]           mem_addr_d;
  logic [LINE_BITS-1:0]  mem_data_d;

  assign word             = cpu_addr_i[4:2];
  assign index            = cpu_addr_i[INDEX_BITS+4:5];
  assign tag              = cpu_addr_i[31:INDEX_BITS+5];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign line       = data_q[index];
  assign victim_tag = tag_q[index];
  assign request    = cpu_memread_i | cpu_memwrite_i;
  assign hit        = valid_q[index] && (victim_tag == tag);
  assign fill       = (state_q == ALLOCATE) && mem_ack_i;
  assign store_hit  = (state_q == IDLE) && cpu_memwrite_i && hit;

  assign cpu_data_o  = line[{word, 5'b0} +: 32];
  assign cpu_stall_o = ((state_q == IDLE) && request && !hit) || (state_q != IDLE);

  // Next state and next memory-port values; the port itself is registered below.
  always_comb begin
    state_d      = state_q;
    mem_enable_d = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = '0;
    mem_data_d   = mem_data_o;

    case (state_q)
      IDLE: begin
        if (request && !hit) begin
          state_d = (valid_q[index] && dirty_q[index]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        if (mem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == WRITEBACK) begin
      mem_enable_d = 1'b1;
      mem_write_d  = 1'b1;
      mem_addr_d   = {victim_tag, index, 5'b0};
      mem_data_d   = line;
    end else if (state_d == ALLOCATE) begin
      mem_enable_d = 1'b1;
      mem_addr_d   = {tag, index, 5'b0};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      state_q      <= state_d;
      mem_enable_o <= mem_enable_d;
      mem_write_o  <= mem_write_d;
      mem_addr_o   <= mem_addr_d;
      mem_data_o   <= mem_data_d;
    end
  end

  // Line status bits; cleared on reset so an aborted fill never looks valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (store_hit) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset.
  always_ff @(posedge clk_i) begin
    if (fill) begin
      tag_q[index]  <= tag;
      data_q[index] <= mem_data_i;
    end else if (store_hit) begin
      data_q[index][{word, 5'b0} +: 32] <= cpu_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: a flat-memory view of the CPU address space plus
// a per-index tag/valid/dirty table predicts load data, stall length and memory traffic.
`timescale 1ns/1ps
module tb_dcache_ctrl;

  localparam int unsigned IB    = 5;
  localparam int unsigned TB    = 32 - IB - 5;
  localparam int unsigned LINES = 1 << IB;
  localparam logic [31:0] NONE  = 32'hFFFF_FFFF;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_memread_i;
  logic         cpu_memwrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  dcache_ctrl #(.INDEX_BITS(IB)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_memread_i  (cpu_memread_i),
    .cpu_memwrite_i (cpu_memwrite_i),
    .cpu_data_o     (cpu_data_o),
    .cpu_stall_o    (cpu_stall_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_data_i     (mem_data_i),
    .mem_ack_i      (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // CPU-visible memory: words written by stores, otherwise whatever the backing memory holds.
  logic [31:0]  flat    [logic [31:0]];
  logic [255:0] backing [logic [31:0]];
  bit           mv [LINES];
  bit           md [LINES];
  logic [TB-1:0] mt [LINES];

  function automatic logic [31:0] init_word(input logic [31:0] la, input int w);
    return la ^ (32'(w) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [255:0] back_line(input logic [31:0] la);
    logic [255:0] l;
    if (backing.exists(la)) return backing[la];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la, w);
    return l;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0]  wa;
    logic [255:0] l;
    wa = {a[31:2], 2'b00};
    if (flat.exists(wa)) return flat[wa];
    l = back_line({a[31:5], 5'b0});
    return l[32*int'(a[4:2]) +: 32];
  endfunction

  function automatic logic [255:0] model_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = model_read(la + 32'(4 * w));
    return l;
  endfunction

  // Memory responder: acks each request mem_lat cycles after it first appears.
  int           mem_lat   = 1;
  int           rcnt      = 0;
  bit           stray_req = 0;
  logic [31:0]  exp_wb_addr = NONE;
  logic [31:0]  exp_rd_addr = NONE;
  logic [31:0]  req_addr;
  logic         req_write;
  logic [31:0]  last_wb_addr = '0;
  logic [31:0]  last_rd_addr = '0;
  logic [255:0] last_wb_line = '0;
  int           wb_count = 0;
  int           rd_count = 0;

  initial begin
    logic [255:0] exp_line;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk_i);
      #2;
      if (rst_i) begin
        mem_ack_i = 1'b0;
        rcnt      = 0;
      end else if (mem_enable_o) begin
        if (rcnt == 0) begin
          req_addr  = mem_addr_o;
          req_write = mem_write_o;
          if (mem_write_o) begin
            check("wb_addr", mem_addr_o, exp_wb_addr);
            exp_line = model_line(mem_addr_o);
            for (int w = 0; w < 8; w++)
              check("wb_data", mem_data_o[w*32 +: 32], exp_line[w*32 +: 32]);
            backing[mem_addr_o] = mem_data_o;
            last_wb_addr = mem_addr_o;
            last_wb_line = mem_data_o;
            wb_count++;
          end else begin
            check("rd_addr", mem_addr_o, exp_rd_addr);
            last_rd_addr = mem_addr_o;
            rd_count++;
          end
        end else begin
          check("req_stable_addr", mem_addr_o, req_addr);
          check("req_stable_write", 32'(mem_write_o), 32'(req_write));
        end
        rcnt++;
        if (rcnt >= mem_lat) begin
          mem_ack_i = 1'b1;
          if (!mem_write_o) mem_data_i = back_line(mem_addr_o);
          rcnt = 0;
        end else begin
          mem_ack_i = 1'b0;
        end
      end else begin
        mem_ack_i = stray_req;
        stray_req = 0;
        rcnt      = 0;
      end
    end
  end

  // Per-cycle compare: load data whenever it is meaningful, and a quiet cache when idle.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (cpu_memread_i && !cpu_stall_o)
        check("load_data", cpu_data_o, model_read(cpu_addr_i));
      if (!cpu_memread_i && !cpu_memwrite_i) begin
        check("idle_stall", 32'(cpu_stall_o), 32'd0);
        check("idle_enable", 32'(mem_enable_o), 32'd0);
      end
    end
  end

  task automatic do_access(input bit st, input bit rd, input logic [31:0] a,
                           input logic [31:0] d, input int lat,
                           output int stall_cyc, output logic [31:0] ld);
    int            idx;
    logic [TB-1:0] tg;
    bit            hit;
    int            exp_cyc;
    idx = int'(a[IB+4:5]);
    tg  = a[31:IB+5];
    hit = mv[idx] && (mt[idx] == tg);
    exp_cyc = hit ? 0 : ((mv[idx] && md[idx]) ? 2 * lat + 1 : lat + 1);
    exp_wb_addr = (!hit && mv[idx] && md[idx]) ? {mt[idx], 5'(idx), 5'b0} : NONE;
    exp_rd_addr = hit ? NONE : {tg, 5'(idx), 5'b0};
    mem_lat        = lat;
    cpu_addr_i     = a;
    cpu_data_i     = d;
    cpu_memread_i  = rd;
    cpu_memwrite_i = st;
    stall_cyc = 0;
    @(negedge clk_i);
    while (cpu_stall_o && stall_cyc <= 500) begin
      stall_cyc++;
      @(negedge clk_i);
    end
    ld = cpu_data_o;
    check("stall_cycles", 32'(stall_cyc), 32'(exp_cyc));
    @(posedge clk_i);
    if (st) flat[{a[31:2], 2'b00}] = d;
    md[idx] = hit ? (md[idx] | st) : st;
    mv[idx] = 1'b1;
    mt[idx] = tg;
    #1;
  endtask

  task automatic idle(input int n, input bit stray);
    cpu_memread_i  = 1'b0;
    cpu_memwrite_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (stray) stray_req = 1;
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_i          = 1'b1;
    cpu_memread_i  = 1'b0;
    cpu_memwrite_i = 1'b0;
    #2;
    check("rst_enable", 32'(mem_enable_o), 32'd0);
    check("rst_stall", 32'(cpu_stall_o), 32'd0);
    check("rst_write", 32'(mem_write_o), 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    foreach (mv[i]) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
    flat.delete();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int           sc;
    int           rd0;
    int           wb0;
    logic [31:0]  ld;
    logic [255:0] l;
    rst_i          = 1'b1;
    cpu_addr_i     = '0;
    cpu_data_i     = '0;
    cpu_memread_i  = 1'b0;
    cpu_memwrite_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    do_reset();

    // Load miss to a fresh line with a slow memory.
    l = back_line(32'h0000_0400);
    l[63:32] = 32'hDEAD_BEEF;
    backing[32'h0000_0400] = l;
    rd0 = rd_count;
    do_access(1'b0, 1'b1, 32'h0000_0404, '0, 10, sc, ld);
    check("t1_stall", 32'(sc), 32'd11);
    check("t1_fetch_addr", last_rd_addr, 32'h0000_0400);
    check("t1_fetch_count", 32'(rd_count - rd0), 32'd1);
    check("t1_data", ld, 32'hDEAD_BEEF);
    rd0 = rd_count;
    do_access(1'b0, 1'b1, 32'h0000_0404, '0, 10, sc, ld);
    check("t1_rehit_stall", 32'(sc), 32'd0);
    check("t1_rehit_fetch", 32'(rd_count - rd0), 32'd0);

    // Store hit then load back.
    do_access(1'b1, 1'b0, 32'h0000_0408, 32'h1234_5678, 3, sc, ld);
    check("t2_store_stall", 32'(sc), 32'd0);
    do_access(1'b0, 1'b1, 32'h0000_0408, '0, 3, sc, ld);
    check("t2_load_stall", 32'(sc), 32'd0);
    check("t2_load_data", ld, 32'h1234_5678);

    // Conflict miss over the dirty line.
    do_access(1'b0, 1'b1, 32'h0000_0004, '0, 3, sc, ld);
    check("t3_stall", 32'(sc), 32'd7);
    check("t3_wb_addr", last_wb_addr, 32'h0000_0400);
    check("t3_wb_word2", last_wb_line[95:64], 32'h1234_5678);
    check("t3_wb_word1", last_wb_line[63:32], 32'hDEAD_BEEF);
    check("t3_fetch_addr", last_rd_addr, 32'h0000_0000);

    // Store miss to a clean index, then evict it.
    wb0 = wb_count;
    do_access(1'b1, 1'b0, 32'h0000_0060, 32'hA5A5_A5A5, 2, sc, ld);
    check("t4_stall", 32'(sc), 32'd3);
    check("t4_no_wb", 32'(wb_count - wb0), 32'd0);
    check("t4_fetch_addr", last_rd_addr, 32'h0000_0060);
    do_access(1'b0, 1'b1, 32'h0000_0460, '0, 2, sc, ld);
    check("t4_evict_stall", 32'(sc), 32'd5);
    check("t4_wb_addr", last_wb_addr, 32'h0000_0060);
    check("t4_wb_word0", last_wb_line[31:0], 32'hA5A5_A5A5);

    // Reset while a fill is outstanding.
    mem_lat        = 20;
    exp_rd_addr    = 32'h0000_0800;
    cpu_addr_i     = 32'h0000_0800;
    cpu_memread_i  = 1'b1;
    cpu_memwrite_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    check("t5_pre_enable", 32'(mem_enable_o), 32'd1);
    do_reset();
    do_access(1'b0, 1'b1, 32'h0000_0800, '0, 2, sc, ld);
    check("t5_remiss_stall", 32'(sc), 32'd3);

    // Single-cycle memory plus idle cycles with stray acks.
    do_access(1'b0, 1'b1, 32'h1000_0010, '0, 1, sc, ld);
    check("t6_stall", 32'(sc), 32'd2);
    idle(5, 1'b1);

    // Randomised traffic over a few conflicting tags.
    for (int n = 0; n < 400; n++) begin
      int          op;
      logic [31:0] a;
      a  = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 5)
         | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      op = $urandom_range(0, 19);
      if (op < 8)       do_access(1'b0, 1'b1, a, $urandom, $urandom_range(1, 4), sc, ld);
      else if (op < 16) do_access(1'b1, 1'b0, a, $urandom, $urandom_range(1, 4), sc, ld);
      else if (op < 18) do_access(1'b1, 1'b1, a, $urandom, $urandom_range(1, 4), sc, ld);
      else if (op < 19) idle($urandom_range(1, 3), 1'($urandom_range(0, 1)));
      else if ($urandom_range(0, 4) == 0) do_reset();
      else idle(1, 1'b0);
    end
    idle(2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-back, write-allocate L1 data cache controller for the MEM stage. Consumes the EX/MEM register outputs (memread, memwrite, result as address, data as store data). Drives stall back to the pipeline registers on a miss. Talks to a slow line-wide data memory through an enable/ack handshake.

Parameters:
INDEX_BITS, 5, number of index bits (2^INDEX_BITS lines); tag width = 32 - INDEX_BITS - 5.
LINE_BITS, 256, line width (8 x 32-bit words); fixed, offset field is addr[4:0].

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
cpu_addr_i  in  32  byte address (EX/MEM result); addr[1:0] ignored
cpu_data_i  in  32  store data (EX/MEM data)
cpu_memread_i  in  1  load request
cpu_memwrite_i  in  1  store request
cpu_data_o  out  32  load data
cpu_stall_o  out  1  holds IF/ID, ID/EX, EX/MEM and MEM/WB while high
mem_enable_o  out  1  memory request valid
mem_write_o  out  1  1 = line write-back, 0 = line fetch
mem_addr_o  out  32  line-aligned address {tag, index, 5'b0}
mem_data_o  out  256  write-back line
mem_data_i  in  256  fetched line
mem_ack_i  in  1  one-cycle completion pulse from memory

Behaviour:
- Address fields: word = addr[4:2], index = addr[INDEX_BITS+4:5], tag = addr[31:INDEX_BITS+5].
- Per-line storage: valid, dirty, tag, 256-bit data.
- Reset (async): all valid and dirty bits = 0, state = IDLE. Outputs: mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, cpu_stall_o = 0. Data and tag arrays are not cleared.
- Request = memread | memwrite. If both are high, treat as a store.
- hit = valid[index] & (tag[index] == tag).
- cpu_data_o: combinational, word[word] of the indexed line. Valid only when memread = 1 and cpu_stall_o = 0. No latency on a hit.
- cpu_stall_o: combinational, (state == IDLE & request & !hit) | (state != IDLE).
- States:
  - IDLE
    - Read hit: no state change.
    - Write hit: at the clock edge, write cpu_data_i into word[word] and set dirty = 1; stall stays 0.
    - Miss with dirty victim: go to WRITEBACK.
    - Miss with clean or invalid victim: go to ALLOCATE.
    - No request: stay in IDLE.
  - WRITEBACK
    - mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = victim line.
    - On mem_ack_i: go to ALLOCATE.
  - ALLOCATE
    - mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {request tag, index, 5'b0}.
    - On mem_ack_i: write mem_data_i into the line, set tag, valid = 1, dirty = 0, go to IDLE.
  - Back in IDLE, the held request re-evaluates as a hit. A store completes on that cycle, so a store miss ends with dirty = 1.
- Memory handshake:
  - mem_enable_o, mem_addr_o, mem_write_o and mem_data_o are registered and stay stable while enable is high.
  - Enable is deasserted in the cycle after ack is sampled; there is no back-to-back reuse of the same request.
  - Memory latency is any value of at least 1 cycle.
  - An ack arriving in IDLE is ignored.
- Stall contract: the pipeline holds cpu_* inputs stable while cpu_stall_o = 1.
- Reset mid-miss: the transaction is aborted, mem_enable_o drops immediately, and the partial line is never marked valid.
- Miss penalty: clean miss = L + 1 stall cycles; dirty miss = 2L + 1 stall cycles (L = memory ack latency).

Test Plan:
1. Reset, then load 0x0000_0404 (index 0, tag 1, word 1). Expect stall = 1 and ALLOCATE with mem_addr_o = 0x0000_0400, mem_write_o = 0. Ack after 10 cycles with word1 = 0xDEAD_BEEF. Next cycle: stall = 0, cpu_data_o = 0xDEAD_BEEF. Repeat the load: no stall, no mem_enable_o.
2. Store 0x1234_5678 to 0x0000_0408 (hit on the line above). Expect no stall. A following load of 0x0000_0408 returns 0x1234_5678 with zero stall.
3. After scenario 2, load 0x0000_0004 (index 0, tag 0, conflict with the dirty line). Expect WRITEBACK with mem_addr_o = 0x0000_0400, mem_write_o = 1, and mem_data_o word2 = 0x1234_5678. After ack, expect ALLOCATE at 0x0000_0000; stall spans 2L + 1 cycles.
4. Store miss to clean index 3, address 0x0000_0060, data 0xA5A5_A5A5. Expect ALLOCATE at 0x0000_0060 only (no writeback). After ack, the store completes; later evicting index 3 triggers a writeback containing 0xA5A5_A5A5.
5. Assert rst_i while in ALLOCATE before ack. Expect mem_enable_o = 0 and stall = 0 immediately. A load of the same address afterwards misses again.
6. Run with 1-cycle ack latency plus idle cycles with no request. Expect a clean-miss stall of exactly 2 cycles, and no stall or memory activity while idle.
